// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: shared game definitions for the Mario-Dash flow
// controller and the blocks that talk to it.
//   - state encodings (3-bit, legacy-compatible localparam constants)
//   - screen/tick constants used across the game
//   - bus widths for level, lives, score and the internal counters
//   - is_banner(): true for the timed banner states (INTRO/DEATH/CLEAR)
package game_sequencer_pkg;

    localparam int TICK_HZ  = 60;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int NUM_LEVELS_DEF = 3;
    localparam int STATE_W        = 3;
    localparam int LEVEL_W        = 2;
    localparam int LIVES_W        = 2;
    localparam int SCORE_W        = 10;
    localparam int BANNER_W       = 8;
    localparam int BOOST_W        = 6;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd1023;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_INTRO     = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAYING   = 3'd2;
    localparam logic [STATE_W-1:0] ST_DEATH     = 3'd3;
    localparam logic [STATE_W-1:0] ST_CLEAR     = 3'd4;
    localparam logic [STATE_W-1:0] ST_WIN       = 3'd5;
    localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'd6;

    function automatic logic is_banner(input logic [STATE_W-1:0] s);
        return (s == ST_INTRO) || (s == ST_DEATH) || (s == ST_CLEAR);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: bundle between the game-flow controller and the
// 60 Hz game world (lava controller, level objects, player logic).
//   master : the game world; drives tick, button and event flags,
//            observes state/level/freeze/lives/score and the events.
//   slave  : the game_sequencer itself.
//
// Protocol: game_tick is a one-clk strobe. Every input flag is a level that
// is only looked at on clk edges where game_tick=1; its value at any other
// edge is don't-care. All outputs are registers that change only on those
// tick edges. level_reset and speed_boost_pulse are raised on tick N and
// dropped on tick N+1, so a consumer gated by game_tick sees each once.
interface game_sequencer_if;
    import game_sequencer_pkg::*;

    logic                game_tick;
    logic                start_btn;
    logic                hit_lava_wall;
    logic                hit_hazard;
    logic                reached_goal;
    logic                coin_pulse;

    logic [STATE_W-1:0]  state;
    logic [LEVEL_W-1:0]  level;
    logic                freeze;
    logic                level_reset;
    logic                speed_boost_pulse;
    logic [LIVES_W-1:0]  lives;
    logic [SCORE_W-1:0]  score;

    modport master (
        output game_tick, start_btn, hit_lava_wall, hit_hazard,
               reached_goal, coin_pulse,
        input  state, level, freeze, level_reset, speed_boost_pulse,
               lives, score
    );

    modport slave (
        input  game_tick, start_btn, hit_lava_wall, hit_hazard,
               reached_goal, coin_pulse,
        output state, level, freeze, level_reset, speed_boost_pulse,
               lives, score
    );

endinterface

// File: rtl/game_sequencer_tick_dwell_timer.sv
// tick_dwell_timer: 8-bit game-tick counter shared by the banner states.
//   clk, rst     : clock, asynchronous active-low reset
//   clear_i      : synchronous clear (wins over tick_en_i)
//   tick_en_i    : count one game tick
//   done_o       : count == BANNER_TICKS-1, i.e. this is the last dwell tick
module tick_dwell_timer
    import game_sequencer_pkg::*;
#(
    parameter int BANNER_TICKS = 120
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic tick_en_i,
    output logic done_o
);

    logic [BANNER_W-1:0] count_q;
    logic [BANNER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 8'(BANNER_TICKS - 1));

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: Mario-Dash game-flow controller.
//   clk, rst : system clock, asynchronous active-low reset
//   bus      : game_sequencer_if.slave
//              in : game_tick, start_btn, hit_lava_wall, hit_hazard,
//                   reached_goal, coin_pulse
//              out: state, level, freeze, level_reset, speed_boost_pulse,
//                   lives, score
// Runs IDLE -> INTRO -> PLAYING -> DEATH/CLEAR -> WIN/GAME_OVER and owns
// the level index, lives and saturating coin score. Every register moves
// only on clk edges qualified by game_tick.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int NUM_LEVELS   = NUM_LEVELS_DEF,
    parameter int START_LIVES  = 3,
    parameter int BANNER_TICKS = 120,
    parameter int BOOST_STEP   = 10
) (
    input  logic             clk,
    input  logic             rst,
    game_sequencer_if.slave  bus
);

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [BOOST_W-1:0] BOOST_LAST = BOOST_W'(BOOST_STEP - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               freeze_q, freeze_d;
    logic               level_reset_q, level_reset_d;
    logic               boost_pulse_q, boost_pulse_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [BOOST_W-1:0] boost_cnt_q, boost_cnt_d;
    logic               start_prev_q, start_prev_d;
    // Low until the first post-reset tick: a button already held through
    // reset must only prime start_prev, not look like a fresh press.
    logic               armed_q, armed_d;

    logic start_now;
    logic hit;
    logic dwell_done;
    logic dwell_clear;
    logic dwell_en;

    assign start_now = bus.start_btn & ~start_prev_q & armed_q;
    assign hit       = bus.hit_lava_wall | bus.hit_hazard;

    // Any state change restarts the banner count, which also covers the
    // DEATH->INTRO and CLEAR->INTRO hops between two banner states.
    assign dwell_clear = bus.game_tick & (state_d != state_q);
    assign dwell_en    = bus.game_tick & is_banner(state_q);

    tick_dwell_timer #(
        .BANNER_TICKS (BANNER_TICKS)
    ) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (dwell_clear),
        .tick_en_i (dwell_en),
        .done_o    (dwell_done)
    );

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        freeze_d      = freeze_q;
        level_reset_d = level_reset_q;
        boost_pulse_d = boost_pulse_q;
        lives_d       = lives_q;
        score_d       = score_q;
        boost_cnt_d   = boost_cnt_q;
        start_prev_d  = start_prev_q;
        armed_d       = armed_q;

        if (bus.game_tick) begin
            level_reset_d = 1'b0;
            boost_pulse_d = 1'b0;
            start_prev_d  = bus.start_btn;
            armed_d       = 1'b1;

            case (state_q)
                ST_IDLE, ST_WIN, ST_GAME_OVER: begin
                    if (start_now) begin
                        state_d       = ST_INTRO;
                        level_d       = '0;
                        lives_d       = LIVES_INIT;
                        score_d       = '0;
                        boost_cnt_d   = '0;
                        level_reset_d = 1'b1;
                    end
                end
                ST_INTRO: begin
                    if (dwell_done) state_d = ST_PLAYING;
                end
                ST_DEATH: begin
                    if (dwell_done) begin
                        state_d       = ST_INTRO;
                        level_reset_d = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (dwell_done) begin
                        state_d       = ST_INTRO;
                        level_d       = level_q + 2'd1;
                        level_reset_d = 1'b1;
                    end
                end
                ST_PLAYING: begin
                    // One action per tick: a hit outranks the goal, and a
                    // coin arriving alongside either is dropped.
                    if (hit) begin
                        if (lives_q <= 2'd1) begin
                            state_d = ST_GAME_OVER;
                            lives_d = '0;
                        end else begin
                            state_d = ST_DEATH;
                            lives_d = lives_q - 2'd1;
                        end
                    end else if (bus.reached_goal) begin
                        state_d = (level_q == LAST_LEVEL) ? ST_WIN : ST_CLEAR;
                    end else if (bus.coin_pulse) begin
                        if (score_q != SCORE_MAX) score_d = score_q + 10'd1;
                        // Keeps counting after the score saturates.
                        if (boost_cnt_q == BOOST_LAST) begin
                            boost_cnt_d   = '0;
                            boost_pulse_d = 1'b1;
                        end else begin
                            boost_cnt_d = boost_cnt_q + 6'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            freeze_d = (state_d != ST_PLAYING);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            level_q       <= '0;
            freeze_q      <= 1'b1;
            level_reset_q <= 1'b0;
            boost_pulse_q <= 1'b0;
            lives_q       <= LIVES_INIT;
            score_q       <= '0;
            boost_cnt_q   <= '0;
            start_prev_q  <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            freeze_q      <= freeze_d;
            level_reset_q <= level_reset_d;
            boost_pulse_q <= boost_pulse_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            boost_cnt_q   <= boost_cnt_d;
            start_prev_q  <= start_prev_d;
            armed_q       <= armed_d;
        end
    end

    assign bus.state             = state_q;
    assign bus.level             = level_q;
    assign bus.freeze            = freeze_q;
    assign bus.level_reset       = level_reset_q;
    assign bus.speed_boost_pulse = boost_pulse_q;
    assign bus.lives             = lives_q;
    assign bus.score             = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed walk through the game flow followed by a
// randomized play session, with a behavioural model of the game rules
// feeding an expected queue that is compared against the DUT every cycle.
module tb_game_sequencer;

    localparam int NUM_LEVELS   = 3;
    localparam int START_LIVES  = 3;
    localparam int BANNER_TICKS = 120;
    localparam int BOOST_STEP   = 10;
    localparam int SCORE_CAP    = 1023;

    localparam int P_IDLE  = 0;
    localparam int P_INTRO = 1;
    localparam int P_PLAY  = 2;
    localparam int P_DEATH = 3;
    localparam int P_CLEAR = 4;
    localparam int P_WIN   = 5;
    localparam int P_OVER  = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_sequencer_if ifc ();

    game_sequencer #(
        .NUM_LEVELS   (NUM_LEVELS),
        .START_LIVES  (START_LIVES),
        .BANNER_TICKS (BANNER_TICKS),
        .BOOST_STEP   (BOOST_STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // ---------------- scoreboard ----------------
    int          n_checks  = 0;
    int          n_err     = 0;
    int          n_printed = 0;
    logic [19:0] exp_q[$];
    logic [19:0] cur_exp   = '0;
    bit          chk_en    = 1'b0;
    logic [19:0] act_vec;

    assign act_vec = {ifc.state, ifc.level, ifc.freeze, ifc.level_reset,
                      ifc.speed_boost_pulse, ifc.lives, ifc.score};

    // ---------------- behavioural model ----------------
    int m_state, m_level, m_lives, m_score, m_coins, m_banner_left;
    bit m_prev, m_armed, m_lr, m_sb;

    function automatic logic [19:0] model_vec();
        return {3'(m_state), 2'(m_level), (m_state != P_PLAY), m_lr, m_sb,
                2'(m_lives), 10'(m_score)};
    endfunction

    task automatic model_reset();
        m_state = P_IDLE; m_level = 0; m_lives = START_LIVES; m_score = 0;
        m_coins = 0; m_banner_left = 0; m_prev = 0; m_armed = 0;
        m_lr = 0; m_sb = 0;
    endtask

    task automatic model_step(input bit s, input bit hl, input bit hh,
                              input bit g, input bit c);
        bit start_now;
        start_now = s && !m_prev && m_armed;
        m_prev  = s;
        m_armed = 1;
        m_lr    = 0;
        m_sb    = 0;
        case (m_state)
            P_IDLE, P_WIN, P_OVER: begin
                if (start_now) begin
                    m_state = P_INTRO; m_banner_left = BANNER_TICKS;
                    m_level = 0; m_lives = START_LIVES; m_score = 0;
                    m_coins = 0; m_lr = 1;
                end
            end
            P_INTRO, P_DEATH, P_CLEAR: begin
                m_banner_left = m_banner_left - 1;
                if (m_banner_left == 0) begin
                    if (m_state == P_INTRO) begin
                        m_state = P_PLAY;
                    end else begin
                        if (m_state == P_CLEAR) m_level = m_level + 1;
                        m_state = P_INTRO; m_banner_left = BANNER_TICKS;
                        m_lr = 1;
                    end
                end
            end
            P_PLAY: begin
                if (hl || hh) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = P_OVER;
                    else begin m_state = P_DEATH; m_banner_left = BANNER_TICKS; end
                end else if (g) begin
                    if (m_level == NUM_LEVELS - 1) m_state = P_WIN;
                    else begin m_state = P_CLEAR; m_banner_left = BANNER_TICKS; end
                end else if (c) begin
                    m_score = (m_score + 1 > SCORE_CAP) ? SCORE_CAP : m_score + 1;
                    m_coins = m_coins + 1;
                    if (m_coins == BOOST_STEP) begin m_sb = 1; m_coins = 0; end
                end
            end
            default: m_state = P_IDLE;
        endcase
        exp_q.push_back(model_vec());
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            n_checks++;
            if (act_vec !== cur_exp) begin
                n_err++;
                if (n_printed < 20) begin
                    n_printed++;
                    $display("FAIL outputs t=%0t got st=%0d lv=%0d fz=%0b lr=%0b sb=%0b li=%0d sc=%0d want st=%0d lv=%0d fz=%0b lr=%0b sb=%0b li=%0d sc=%0d",
                             $time, act_vec[19:17], act_vec[16:15], act_vec[14],
                             act_vec[13], act_vec[12], act_vec[11:10], act_vec[9:0],
                             cur_exp[19:17], cur_exp[16:15], cur_exp[14],
                             cur_exp[13], cur_exp[12], cur_exp[11:10], cur_exp[9:0]);
                end
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_lit({tag, "_state"},  int'(ifc.state), P_IDLE);
        check_lit({tag, "_level"},  int'(ifc.level), 0);
        check_lit({tag, "_freeze"}, int'(ifc.freeze), 1);
        check_lit({tag, "_lr"},     int'(ifc.level_reset), 0);
        check_lit({tag, "_boost"},  int'(ifc.speed_boost_pulse), 0);
        check_lit({tag, "_lives"},  int'(ifc.lives), START_LIVES);
        check_lit({tag, "_score"},  int'(ifc.score), 0);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at a negedge.
    task automatic do_tick(input bit s, input bit hl, input bit hh,
                           input bit g, input bit c);
        int gap;
        ifc.start_btn     = s;
        ifc.hit_lava_wall = hl;
        ifc.hit_hazard    = hh;
        ifc.reached_goal  = g;
        ifc.coin_pulse    = c;
        ifc.game_tick     = 1'b1;
        @(posedge clk);
        #1;
        model_step(s, hl, hh, g, c);
        @(negedge clk);
        ifc.game_tick = 1'b0;
        gap = $urandom_range(0, 1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) do_tick(0, 0, 0, 0, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5000000;
        n_err++;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit rs;
        ifc.game_tick = 0; ifc.start_btn = 0; ifc.hit_lava_wall = 0;
        ifc.hit_hazard = 0; ifc.reached_goal = 0; ifc.coin_pulse = 0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        cur_exp = model_vec();
        chk_en  = 1'b1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle with button low
        wait_ticks(5);
        check_lit("idle_state", int'(ifc.state), P_IDLE);
        check_lit("idle_lives", int'(ifc.lives), 3);
        check_lit("idle_freeze", int'(ifc.freeze), 1);

        // Start: INTRO with one-tick level_reset, then 120-tick dwell
        do_tick(1, 0, 0, 0, 0);
        check_lit("start_state", int'(ifc.state), P_INTRO);
        check_lit("start_lr", int'(ifc.level_reset), 1);
        do_tick(0, 0, 0, 0, 0);
        check_lit("start_lr_drop", int'(ifc.level_reset), 0);
        wait_ticks(118);
        check_lit("intro_119", int'(ifc.state), P_INTRO);
        wait_ticks(1);
        check_lit("intro_exit", int'(ifc.state), P_PLAY);
        check_lit("play_freeze", int'(ifc.freeze), 0);

        // Ten coins: boost on the tenth only
        repeat (9) do_tick(0, 0, 0, 0, 1);
        check_lit("coin9_boost", int'(ifc.speed_boost_pulse), 0);
        do_tick(0, 0, 0, 0, 1);
        check_lit("coin10_score", int'(ifc.score), 10);
        check_lit("coin10_boost", int'(ifc.speed_boost_pulse), 1);
        do_tick(0, 0, 0, 0, 0);
        check_lit("boost_drop", int'(ifc.speed_boost_pulse), 0);

        // Hazard + goal + coin together: a hit, coin dropped
        repeat (9) do_tick(0, 0, 0, 0, 1);
        do_tick(0, 0, 1, 1, 1);
        check_lit("combo_state", int'(ifc.state), P_DEATH);
        check_lit("combo_lives", int'(ifc.lives), 2);
        check_lit("combo_score", int'(ifc.score), 19);
        check_lit("combo_boost", int'(ifc.speed_boost_pulse), 0);
        wait_ticks(BANNER_TICKS);
        check_lit("death_exit", int'(ifc.state), P_INTRO);
        check_lit("death_level", int'(ifc.level), 0);
        check_lit("death_lr", int'(ifc.level_reset), 1);
        wait_ticks(BANNER_TICKS);
        // Dropped coin leaves the boost count at 9, so this coin boosts
        do_tick(0, 0, 0, 0, 1);
        check_lit("after_drop_boost", int'(ifc.speed_boost_pulse), 1);
        repeat (1023) do_tick(0, 0, 0, 0, 1);
        check_lit("score_sat", int'(ifc.score), 1023);

        // Lava hit, then climb through the levels to WIN
        do_tick(0, 1, 0, 0, 0);
        check_lit("lava_lives", int'(ifc.lives), 1);
        wait_ticks(2 * BANNER_TICKS);
        do_tick(0, 0, 0, 1, 0);
        check_lit("goal0_state", int'(ifc.state), P_CLEAR);
        wait_ticks(BANNER_TICKS);
        check_lit("clear_level", int'(ifc.level), 1);
        check_lit("clear_state", int'(ifc.state), P_INTRO);
        wait_ticks(BANNER_TICKS);
        do_tick(0, 0, 0, 1, 0);
        wait_ticks(2 * BANNER_TICKS);
        check_lit("level2", int'(ifc.level), 2);
        do_tick(0, 0, 0, 1, 0);
        check_lit("win_state", int'(ifc.state), P_WIN);
        check_lit("win_freeze", int'(ifc.freeze), 1);

        // New game from WIN
        do_tick(1, 0, 0, 0, 0);
        check_lit("regame_state", int'(ifc.state), P_INTRO);
        check_lit("regame_level", int'(ifc.level), 0);
        check_lit("regame_lives", int'(ifc.lives), 3);
        check_lit("regame_score", int'(ifc.score), 0);
        wait_ticks(BANNER_TICKS);

        // Three hits to GAME_OVER
        do_tick(0, 1, 0, 0, 0);
        wait_ticks(2 * BANNER_TICKS);
        do_tick(0, 1, 0, 0, 0);
        wait_ticks(2 * BANNER_TICKS);
        do_tick(0, 1, 0, 0, 0);
        check_lit("over_state", int'(ifc.state), P_OVER);
        check_lit("over_lives", int'(ifc.lives), 0);
        check_lit("over_freeze", int'(ifc.freeze), 1);

        // Reset in the middle of a CLEAR banner, button held across release
        do_tick(1, 0, 0, 0, 0);
        wait_ticks(BANNER_TICKS);
        repeat (3) do_tick(0, 0, 0, 0, 1);
        do_tick(0, 0, 0, 1, 0);
        wait_ticks(30);
        check_lit("preclear_state", int'(ifc.state), P_CLEAR);
        ifc.start_btn = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        exp_q.delete();
        cur_exp = model_vec();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) do_tick(1, 0, 0, 0, 0);
        check_lit("held_no_start", int'(ifc.state), P_IDLE);
        do_tick(0, 0, 0, 0, 0);
        do_tick(1, 0, 0, 0, 0);
        check_lit("repress_start", int'(ifc.state), P_INTRO);

        // Randomized session
        rs = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            do_tick(rs,
                    ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 2) == 0));
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for Mario-Dash.
- Sequences IDLE → intro → play → death/clear → win/game-over, and owns the level index, lives and score.
- Drives freeze, level, speed_boost_pulse and a per-level object reset into the lava controller and the other 60 Hz game-tick-driven blocks.
- Consumes the collision, goal and coin events those blocks report.

Parameters:
- NUM_LEVELS, 3, number of levels; the last index is level NUM_LEVELS-1.
- START_LIVES, 3, lives loaded at new-game start (1..3).
- BANNER_TICKS, 120, dwell in the INTRO/DEATH/CLEAR states in game ticks (1..255; about 2 s at 60 Hz).
- BOOST_STEP, 10, accepted coins per speed_boost_pulse (2..63).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- game_tick  in  1  one-clk strobe at 60 Hz; all state updates occur only on clk edges with game_tick=1
- start_btn  in  1  synchronized start button level
- hit_lava_wall  in  1  lava collision flag, sampled on game_tick
- hit_hazard  in  1  enemy/pit collision flag, sampled on game_tick
- reached_goal  in  1  player at level flag, sampled on game_tick
- coin_pulse  in  1  coin collected, sampled on game_tick
- state  out  3  current state encoding
- level  out  2  current level index
- freeze  out  1  1 in every state except PLAYING
- level_reset  out  1  object reset for level blocks
- speed_boost_pulse  out  1  lava speed-up event
- lives  out  2  remaining lives
- score  out  10  coin score, saturating

Behaviour:
- Reset values (async): state=IDLE, level=0, freeze=1, level_reset=0, speed_boost_pulse=0, lives=START_LIVES, score=0; banner counter, boost counter and start_prev all 0.
- Reset mid-operation aborts immediately to these values.
- All outputs are registered and change only on tick edges. There is no combinational path from inputs to outputs.
- Event outputs (level_reset, speed_boost_pulse):
  - Set on tick N, cleared on tick N+1.
  - Consumers gating on game_tick therefore see each event exactly once.
- Start edge: start_now = start_btn & ~start_prev. start_prev is updated every tick.
- State encodings: IDLE=0, INTRO=1, PLAYING=2, DEATH=3, CLEAR=4, WIN=5, GAME_OVER=6. Code 7 is illegal and recovers to IDLE on the next tick.
- IDLE, WIN, GAME_OVER on start_now: → INTRO with level=0, lives=START_LIVES, score=0, boost_cnt=0, level_reset=1.
- INTRO, DEATH, CLEAR:
  - The banner counter clears on entry and increments per tick.
  - On the tick where count==BANNER_TICKS-1, the state exits, so dwell is exactly BANNER_TICKS ticks.
  - INTRO exits → PLAYING.
  - DEATH exits → INTRO, same level, level_reset=1.
  - CLEAR exits → INTRO, level+1, level_reset=1.
- PLAYING, per-tick priority (only one action per tick):
  1. hit = hit_lava_wall|hit_hazard. lives decrements; if lives was 1 → GAME_OVER with lives=0, else → DEATH.
  2. reached_goal: level==NUM_LEVELS-1 → WIN, else → CLEAR.
  3. coin_pulse:
     - score+1, saturating at 1023.
     - boost_cnt+1. When it reaches BOOST_STEP, set speed_boost_pulse=1 and clear boost_cnt.
     - boost_cnt keeps counting when score is saturated.
- Simultaneous events:
  - A coin on the same tick as a hit or goal is dropped.
  - Hit and goal together counts as a hit.
- Events outside PLAYING are ignored, including coins during banners.
- start_btn held through reset does not start a game. start_prev resets to 0, so the first tick would see an edge; therefore start_prev loads 1 if start_btn is high on the first post-reset tick, without starting.
- freeze = (next state != PLAYING), registered alongside state.

Decomposition:
- Shared package/include game_defs: state encodings, TICK_HZ=60, SCREEN_W=640, SCREEN_H=480, level count and width constants.
- One sub-module, tick_dwell_timer:
  - 8-bit counter with clear and tick-enable inputs.
  - done output when count==BANNER_TICKS-1.
  - Instantiated once and shared by INTRO/DEATH/CLEAR.

Test Plan:
- Reset, then 5 ticks with start_btn low → state=0, freeze=1, lives=3, score=0, no pulses. Raise start_btn → next tick state=1, level_reset=1 for exactly one tick; after 120 ticks state=2, freeze=0.
- In PLAYING, 10 coin ticks → score=10, speed_boost_pulse high on the 10th tick only. Then 1023 more coins → score holds at 1023.
- hit_lava_wall with lives=3 → DEATH, lives=2; 120 ticks later INTRO, level unchanged, level_reset=1. A third hit → GAME_OVER, lives=0, freeze=1.
- reached_goal at level 0 → CLEAR → INTRO with level=1. At level 2, reached_goal → WIN. start edge → INTRO, level=0, lives=3, score=0.
- Same tick hit_hazard+reached_goal+coin_pulse → DEATH, score unchanged, no boost.
- Async rst asserted mid-CLEAR banner → all outputs at reset values immediately. start_btn held high across release → no game start until it is released and re-pressed.
